// File: rtl/unidad_control_pkg.sv
// unidad_control_pkg: opcode, condition, ALU and write-back select encodings.
package unidad_control_pkg;
  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UND = 2'b11} op_e;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_BIC = 4'b1110;
  localparam logic [3:0] ALU_MVN = 4'b1111;
  localparam logic [1:0] DI_ALU = 2'b00;
  localparam logic [1:0] DI_MEM = 2'b01;
  localparam logic [1:0] DI_PC4 = 2'b10;
  // Test/compare and carry variants reuse the plain ALU ops; carry comes from cin.
  function automatic logic [3:0] remap_cmd(input logic [3:0] c);
    return c == 4'b1000 ? ALU_AND :
           c == 4'b1001 ? ALU_EOR :
           (c == 4'b1010 || c == 4'b0110) ? ALU_SUB :
           (c == 4'b1011 || c == 4'b0101) ? ALU_ADD :
           c == 4'b0111 ? ALU_RSB : c;
  endfunction
endpackage

// File: rtl/unidad_control_if.sv
// unidad_control_if: instruction fields in, datapath controls out.
interface unidad_control_if;
  logic [1:0] operation;
  logic [5:0] opcodes;
  logic [3:0] condicion;
  logic       zero;
  logic       selPC;
  logic       regWr;
  logic       selAddWr;
  logic [3:0] opALU;
  logic       cin;
  logic [1:0] selDiWr;
  logic       selOperaB;
  logic       memWr;
  logic       flag_z;
  modport master (output operation, opcodes, condicion, zero,
                  input selPC, regWr, selAddWr, opALU, cin, selDiWr, selOperaB, memWr, flag_z);
  modport slave  (input operation, opcodes, condicion, zero,
                  output selPC, regWr, selAddWr, opALU, cin, selDiWr, selOperaB, memWr, flag_z);
endinterface

// File: rtl/unidad_control_cond_check.sv
// cond_check: Z flag register and condition-pass evaluation against the held Z.
module cond_check
  import unidad_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond_i,
  input  logic       flag_en_i,
  input  logic       zero_i,
  output logic       cp_o,
  output logic       z_o
);
  logic z_q, z_d;
  assign cp_o = cond_i == COND_EQ ? z_q : cond_i == COND_NE ? ~z_q : cond_i == COND_AL;
  assign z_d  = (cp_o & flag_en_i) ? zero_i : z_q;
  assign z_o  = z_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) z_q <= 1'b0;
    else z_q <= z_d;
endmodule

// File: rtl/unidad_control.sv
// unidad_control: combinational main decoder with conditional execution on Z.
module unidad_control
  import unidad_control_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  unidad_control_if.slave bus
);
  logic is_dp, is_mem, is_br, cp, u, l;
  logic [3:0] cmd, dp_alu;
  assign is_dp  = bus.operation == OP_DP;
  assign is_mem = bus.operation == OP_MEM;
  assign is_br  = bus.operation == OP_BR;
  assign cmd    = bus.opcodes[4:1];
  assign u      = bus.opcodes[3];
  assign l      = bus.opcodes[0];
  assign dp_alu = remap_cmd(cmd);
  cond_check u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond_i    (bus.condicion),
    .flag_en_i (is_dp & bus.opcodes[0]),
    .zero_i    (bus.zero),
    .cp_o      (cp),
    .z_o       (bus.flag_z)
  );
  assign bus.opALU     = is_dp ? dp_alu : (is_mem & ~u) ? ALU_SUB : ALU_ADD;
  assign bus.cin       = is_dp ? (dp_alu == ALU_SUB || dp_alu == ALU_RSB) : is_mem & ~u;
  assign bus.selOperaB = is_dp ? bus.opcodes[5] : is_mem ? ~bus.opcodes[5] : is_br;
  assign bus.selDiWr   = is_mem ? DI_MEM : is_br ? DI_PC4 : DI_ALU;
  assign bus.selAddWr  = is_br;
  // Architectural side effects are held off while reset is asserted.
  assign bus.regWr = rst_n & cp & ((is_dp & cmd[3:2] != 2'b10) | (is_mem & l) | (is_br & bus.opcodes[4]));
  assign bus.memWr = rst_n & cp & is_mem & ~l;
  assign bus.selPC = rst_n & cp & is_br;
endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: vector table plus reset corner sequences, scoreboarded.
module tb_unidad_control;
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  opc;
    logic [3:0]  cnd;
    logic        zr;
    logic        step;
    logic [12:0] exp;
    logic        exp_z;
    string       name;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  vec_t vt[$];
  logic [12:0] exp_q[$];
  string nm_q[$];
  unidad_control_if bus ();
  unidad_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input logic [1:0] op, input logic [5:0] opc, input logic [3:0] cnd, input logic zr,
                     input logic step, input logic [12:0] e, input logic ez, input string nm);
    vec_t v;
    v.op = op; v.opc = opc; v.cnd = cnd; v.zr = zr; v.step = step; v.exp = e; v.exp_z = ez; v.name = nm;
    vt.push_back(v);
  endtask
  task automatic drive(input logic [1:0] op, input logic [5:0] opc, input logic [3:0] cnd, input logic zr,
                       input logic [12:0] e, input string nm);
    bus.operation = op; bus.opcodes = opc; bus.condicion = cnd; bus.zero = zr;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask
  task automatic check_out();
    logic [12:0] g, e;
    string nm;
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    nm = nm_q.pop_front();
    g = {bus.selPC, bus.regWr, bus.selAddWr, bus.opALU, bus.cin, bus.selDiWr, bus.selOperaB, bus.memWr};
    if (g !== e) begin
      fails++;
      $display("FAIL %s: outputs {selPC,regWr,selAddWr,opALU,cin,selDiWr,selOperaB,memWr} got %b expected %b", nm, g, e);
    end
  endtask
  task automatic check_z(input logic e, input string nm);
    tests++;
    if (bus.flag_z !== e) begin
      fails++;
      $display("FAIL %s_z: Z got %b expected %b", nm, bus.flag_z, e);
    end
  endtask
  initial begin
    add(2'b00, 6'b111010, 4'hE, 1'b1, 1'b1, 13'b0_1_0_1101_0_00_1_0, 1'b0, "mov_imm");
    add(2'b00, 6'b000101, 4'hE, 1'b1, 1'b1, 13'b0_1_0_0010_1_00_0_0, 1'b1, "subs");
    add(2'b10, 6'b000000, 4'h0, 1'b0, 1'b1, 13'b1_0_1_0100_0_10_1_0, 1'b1, "beq_taken");
    add(2'b10, 6'b000000, 4'h1, 1'b0, 1'b1, 13'b0_0_1_0100_0_10_1_0, 1'b1, "bne_not");
    add(2'b00, 6'b010101, 4'hE, 1'b0, 1'b1, 13'b0_0_0_0010_1_00_0_0, 1'b0, "cmp");
    add(2'b10, 6'b000000, 4'h0, 1'b0, 1'b0, 13'b0_0_1_0100_0_10_1_0, 1'b0, "beq_not");
    add(2'b01, 6'b011000, 4'hE, 1'b1, 1'b1, 13'b0_0_0_0100_0_01_1_1, 1'b0, "str");
    add(2'b01, 6'b011001, 4'hE, 1'b1, 1'b1, 13'b0_1_0_0100_0_01_1_0, 1'b0, "ldr");
    add(2'b10, 6'b110000, 4'hE, 1'b0, 1'b1, 13'b1_1_1_0100_0_10_1_0, 1'b0, "bl");
    add(2'b10, 6'b110000, 4'h5, 1'b0, 1'b1, 13'b0_0_1_0100_0_10_1_0, 1'b0, "bl_cond_fail");
    add(2'b11, 6'b111111, 4'hE, 1'b1, 1'b1, 13'b0_0_0_0100_0_00_0_0, 1'b0, "undef");
    add(2'b00, 6'b010001, 4'h0, 1'b1, 1'b1, 13'b0_0_0_0000_0_00_0_0, 1'b0, "tst_eq_fail");
    add(2'b00, 6'b001010, 4'hE, 1'b1, 1'b1, 13'b0_1_0_0100_0_00_0_0, 1'b0, "adc");
    add(2'b00, 6'b001110, 4'hE, 1'b1, 1'b1, 13'b0_1_0_0011_1_00_0_0, 1'b0, "rsc");
    add(2'b01, 6'b100001, 4'hE, 1'b1, 1'b1, 13'b0_1_0_0010_1_01_0_0, 1'b0, "ldr_down_reg");
    add(2'b00, 6'b010110, 4'hE, 1'b1, 1'b1, 13'b0_0_0_0100_0_00_0_0, 1'b0, "cmn");
    add(2'b00, 6'b111010, 4'hC, 1'b1, 1'b1, 13'b0_0_0_1101_0_00_1_0, 1'b0, "mov_gt");
    add(2'b00, 6'b100011, 4'hE, 1'b1, 1'b1, 13'b0_1_0_0001_0_00_1_0, 1'b1, "eors_imm");
    add(2'b00, 6'b010011, 4'h0, 1'b0, 1'b1, 13'b0_0_0_0001_0_00_0_0, 1'b0, "teq_eq_old_z");
    add(2'b00, 6'b000101, 4'h0, 1'b1, 1'b1, 13'b0_0_0_0010_1_00_0_0, 1'b0, "subs_eq_fail");
    drive(2'b00, 6'b111010, 4'hE, 1'b1, 13'b0_0_0_1101_0_00_1_0, "mov_in_reset");
    check_out();
    check_z(1'b0, "reset");
    @(posedge clk); #1;
    check_z(1'b0, "reset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].opc, vt[i].cnd, vt[i].zr, vt[i].exp, vt[i].name);
      check_out();
      if (vt[i].step) begin
        @(posedge clk); #1;
      end
      check_z(vt[i].exp_z, vt[i].name);
    end
    @(negedge clk);
    drive(2'b00, 6'b000101, 4'hE, 1'b1, 13'b0_1_0_0010_1_00_0_0, "subs_pre_rst");
    check_out();
    @(posedge clk); #1;
    check_z(1'b1, "subs_pre_rst");
    @(negedge clk);
    drive(2'b01, 6'b011000, 4'hE, 1'b0, 13'b0_0_0_0100_0_01_1_1, "str_pre_rst");
    check_out();
    rst_n = 1'b0;
    drive(2'b01, 6'b011000, 4'hE, 1'b0, 13'b0_0_0_0100_0_01_1_0, "str_in_rst");
    check_out();
    check_z(1'b0, "async_clear");
    @(posedge clk); #1;
    check_z(1'b0, "held_in_rst");
    rst_n = 1'b1;
    drive(2'b01, 6'b011000, 4'hE, 1'b0, 13'b0_0_0_0100_0_01_1_1, "str_post_rst");
    check_out();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/unidad_control.md
# unidad_control

Main decoder and conditional-execution unit of the Pac-ARM single-cycle datapath. From the instruction's op, funct and cond fields it generates the ALU operation, operand and write-back selects, and the register-file, memory and PC controls. It holds a registered Z flag, loaded from the ALU `zero` output by flag-setting data-processing instructions, and uses it to evaluate the condition field.

## Interface
- Parameters: none.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `operation` input 2: instr[27:26]. 00 = data processing (DP), 01 = memory, 10 = branch, 11 = undefined.
- `opcodes` input 6: instr[25:20] (funct).
  - DP: [5] I, [4:1] cmd, [0] S.
  - Memory: [5] ~I, [3] U, [0] L.
  - Branch: [4] link.
- `condicion` input 4: instr[31:28] cond field.
- `zero` input 1: ALU zero result of the current instruction.
- `selPC` output 1: 1 selects the branch target, 0 selects PC+4.
- `regWr` output 1: register-file write enable.
- `selAddWr` output 1: write address; 0 = Rd, 1 = R14.
- `opALU` output 4: ALU operation.
- `cin` output 1: ALU carry-in.
- `selDiWr` output 2: write-data source; 00 = ALU, 01 = memory read data, 10 = PC+4, 11 unused.
- `selOperaB` output 1: ALU operand B; 0 = register, 1 = immediate/offset.
- `memWr` output 1: data-memory write enable.

## Operation
- Condition pass (`cp`), evaluated on the registered flag Z:
  - 0000 EQ: Z = 1.
  - 0001 NE: Z = 0.
  - 1110 AL: always.
  - All other codes never pass.
- DP (operation 00):
  - `opALU` = cmd, with these remaps: TST 1000→0000, TEQ 1001→0001, CMP 1010→0010, CMN 1011→0100, ADC 0101→0100, SBC 0110→0010, RSC 0111→0011.
  - `cin` = 1 when the remapped `opALU` is 0010 or 0011, else 0.
  - `selOperaB` = I.
  - `selDiWr` = 00; `selAddWr` = 0.
  - `regWr` = `cp` and cmd not in 1000..1011.
  - `memWr` = 0; `selPC` = 0.
  - Z loads `zero` at the next edge when `cp` and S = 1.
- Memory (operation 01):
  - `opALU` = 0100 when U = 1, 0010 when U = 0.
  - `cin` = ~U.
  - `selOperaB` = ~opcodes[5].
  - `selAddWr` = 0; `selDiWr` = 01.
  - `regWr` = `cp` and L; `memWr` = `cp` and ~L.
  - `selPC` = 0; Z unchanged.
- Branch (operation 10):
  - `opALU` = 0100; `cin` = 0; `selOperaB` = 1.
  - `selPC` = `cp`; `memWr` = 0.
  - `regWr` = `cp` and link; `selAddWr` = 1; `selDiWr` = 10.
  - Z unchanged.
- Undefined (operation 11):
  - `regWr`, `memWr`, `selPC` = 0.
  - `opALU` = 0100; all other outputs 0; Z unchanged.
- Example: `opcodes` 111010, `condicion` 1110, `operation` 00 is MOV immediate. Required outputs: `opALU` 1101, `selOperaB` 1, `regWr` 1, `cin` 0, `selDiWr` 00, `memWr` 0, `selPC` 0. Z does not change.

## Timing
- All outputs are combinational from the inputs and Z, valid in the same cycle. There is no latency.
- Z is the only state and changes only on a rising `clk` edge or on reset.
- `cp` always uses the Z value held before the current instruction. A flag-setting conditional instruction therefore tests the old Z; a new value is visible from the next cycle.
- `rst_n` low:
  - Z clears to 0 immediately.
  - `regWr`, `memWr`, `selPC` are forced to 0 regardless of inputs.
  - Other outputs still decode normally.
- Reset deassertion: Z = 0 holds until the first qualifying edge. Deasserting reset mid-instruction takes effect combinationally.
- `zero` is sampled only at edges where the flag load is enabled.

## Structure
- Package `unidad_control_pkg`:
  - enum of `operation` codes.
  - cond codes EQ, NE, AL.
  - `opALU` codes: AND, EOR, SUB, RSB, ADD, ORR, MOV, BIC, MVN.
  - `selDiWr` codes.
- One sub-module, `cond_check`: holds the Z register and its async reset, evaluates `cp`, and outputs `cp` and Z.
- The top level is a combinational decoder.

## Test plan
- Reset, then `operation` 00, `opcodes` 111010, `condicion` 1110, `zero` 1 -> `opALU` 1101, `selOperaB` 1, `regWr` 1, `memWr` 0, `selPC` 0; Z stays 0 after an edge.
- SUBS: `opcodes` 000101, AL, `zero` 1, then one clock edge -> `opALU` 0010, `cin` 1, Z = 1. Next, branch EQ (`operation` 10, `condicion` 0000) -> `selPC` 1; with NE -> `selPC` 0.
- CMP: `opcodes` 010101, AL, `zero` 0 -> `regWr` 0, `opALU` 0010, `cin` 1, Z = 0 after the edge.
- Store: `operation` 01, `opcodes` 011000, AL -> `memWr` 1, `regWr` 0, `opALU` 0100, `selOperaB` 1. Load: `opcodes` 011001 -> `regWr` 1, `selDiWr` 01.
- BL: `operation` 10, `opcodes` 110000, AL -> `selPC` 1, `regWr` 1, `selAddWr` 1, `selDiWr` 10. With `condicion` 0101 -> `selPC` 0, `regWr` 0.
- Pulse `rst_n` low while Z = 1 and an AL store is applied -> Z clears immediately and `memWr` is 0 during reset. Undefined `operation` 11 -> all write enables 0.
